seg7_encoder: RTL and testbench

SEG7_ENCODER -- requirements
Module: seg7_encoder

---
 rtl/seg7_encoder.sv | 114 +++++++++++
 tb/tb_seg7_encoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_encoder.sv
// seg7_encoder: debounces a 7-segment pattern, decodes it to a glyph code and offers it on a valid/ready handshake.
// Define SEG7_ERR_CNT_EN to add the saturating err_count output for undecodable accepted patterns.
module seg7_encoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  output logic [4:0] code,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       code_err,
  output logic       overrun
`ifdef SEG7_ERR_CNT_EN
  ,output logic [7:0] err_count
`endif
);
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);
  state_t state, state_n;
  logic [6:0] s1, seg_s, cand, cand_n, last, last_n;
  logic [3:0] cnt, cnt_n;
  logic trk, trk_n, acc, hs, load, drop, dec_err;
  logic [4:0] dec_code;
  always_comb begin
    dec_code = 5'd31;
    dec_err = 1'b0;
    case (cand)
      7'h3F: dec_code = 5'd0;
      7'h06: dec_code = 5'd1;
      7'h5B: dec_code = 5'd2;
      7'h4F: dec_code = 5'd3;
      7'h66: dec_code = 5'd4;
      7'h6D: dec_code = 5'd5;
      7'h7D: dec_code = 5'd6;
      7'h07: dec_code = 5'd7;
      7'h7F: dec_code = 5'd8;
      7'h6F: dec_code = 5'd9;
      7'h77: dec_code = 5'd10;
      7'h7C: dec_code = 5'd11;
      7'h39: dec_code = 5'd12;
      7'h5E: dec_code = 5'd13;
      7'h79: dec_code = 5'd14;
      7'h71: dec_code = 5'd15;
      7'h00: dec_code = 5'd16;
      7'h40: dec_code = 5'd17;
      default: dec_err = 1'b1;
    endcase
  end
  // Stability tracker runs in every state, including while a result is held.
  always_comb begin
    acc = trk && cnt == STABLE;
    trk_n = trk;
    cand_n = cand;
    cnt_n = cnt;
    last_n = last;
    if (acc) begin
      trk_n = 1'b0;
      last_n = cand;
    end else if (trk) begin
      if (seg_s == last) trk_n = 1'b0;
      else if (seg_s == cand) cnt_n = cnt + 4'd1;
      else begin
        cand_n = seg_s;
        cnt_n = 4'd1;
      end
    end else if (seg_s != last) begin
      trk_n = 1'b1;
      cand_n = seg_s;
      cnt_n = 4'd1;
    end
  end
  always_comb begin
    hs = code_valid && code_ready;
    load = acc && (!code_valid || hs);
    drop = acc && !load;
    state_n = (load || (state == HOLD && !hs)) ? HOLD : trk_n ? SETTLE : IDLE;
  end
  always_comb code_valid = state == HOLD;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      seg_s <= '0;
      state <= IDLE;
      trk <= 1'b0;
      cand <= '0;
      cnt <= '0;
      last <= '0;
      code <= '0;
      code_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      s1 <= seg;
      seg_s <= s1;
      state <= state_n;
      trk <= trk_n;
      cand <= cand_n;
      cnt <= cnt_n;
      last <= last_n;
      overrun <= drop;
      if (load) begin
        code <= dec_code;
        code_err <= dec_err;
      end
    end
  end
`ifdef SEG7_ERR_CNT_EN
  // Counts dropped invalid acceptances too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_count <= '0;
    else if (acc && dec_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif
endmodule

// File: tb/tb_seg7_encoder.sv
// tb_seg7_encoder: directed checks of debounce, decode, handshake, overrun and reset behaviour.
module tb_seg7_encoder;
  logic clk, rst_n, code_ready, code_valid, code_err, overrun;
  logic [6:0] seg, seg1;
  logic [4:0] code, code1;
  logic valid1, err1, ovr1;
  logic [7:0] err_count, ec1;
  int errors = 0;
  int checks = 0;
  seg7_encoder dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .code(code), .code_valid(code_valid),
    .code_ready(code_ready), .code_err(code_err), .overrun(overrun)
`ifdef SEG7_ERR_CNT_EN
    ,.err_count(err_count)
`endif
  );
  seg7_encoder #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .seg(seg1), .code(code1), .code_valid(valid1),
    .code_ready(1'b1), .code_err(err1), .overrun(ovr1)
`ifdef SEG7_ERR_CNT_EN
    ,.err_count(ec1)
`endif
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!code_valid && n < max) begin
      step(1);
      n++;
    end
    checks++;
    if (code_valid !== 1'b1) begin errors++; $display("FAIL wait_valid: no code_valid within %0d cycles", max); end
  endtask
  task automatic test_reset;
    rst_n = 0;
    step(2);
    checks++; if (code !== 5'd0) begin errors++; $display("FAIL rst_code: got %0d want 0", code); end
    checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", code_valid); end
    checks++; if (code_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", code_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b want 0", overrun); end
`ifdef SEG7_ERR_CNT_EN
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_err_count: got %0d want 0", err_count); end
`endif
    rst_n = 1;
    step(10);
    checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL rst_blank: got valid %b want 0", code_valid); end
  endtask
  task automatic test_stable1;
    seg1 = 7'h66;
    step(3);
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL s1_early: got %b want 0", valid1); end
    step(1);
    checks++; if (valid1 !== 1'b1 || code1 !== 5'd4) begin errors++; $display("FAIL s1_accept: got valid %b code %0d want 1/4", valid1, code1); end
    step(1);
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL s1_clear: got %b want 0", valid1); end
  endtask
  task automatic test_latency;
    code_ready = 1;
    seg = 7'h06;
    step(6);
    checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL lat_early: got %b want 0", code_valid); end
    step(1);
    checks++; if (code_valid !== 1'b1 || code !== 5'd1 || code_err !== 1'b0) begin errors++; $display("FAIL lat_accept: got valid %b code %0d err %b want 1/1/0", code_valid, code, code_err); end
    step(1);
    checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL lat_one_cycle: got %b want 0", code_valid); end
    step(2);
    checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL lat_no_repeat: got %b want 0", code_valid); end
  endtask
  task automatic test_hold;
    int n, bad;
    code_ready = 0;
    seg = 7'h3F;
    wait_valid(12, n);
    checks++; if (n != 7) begin errors++; $display("FAIL hold_latency: got %0d want 7", n); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (code_valid !== 1'b1 || code !== 5'd0 || code_err !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable: got %0d unstable cycles want 0", bad); end
    code_ready = 1;
    step(1);
    checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL hold_release: got %b want 0", code_valid); end
  endtask
  task automatic test_toggle;
    int n, seen;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      seg = (i % 2 == 0) ? 7'h7F : 7'h6F;
      step(1);
      if (code_valid) seen++;
      step(1);
      if (code_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL toggle_quiet: got %0d valid cycles want 0", seen); end
    wait_valid(12, n);
    checks++; if (code !== 5'd9) begin errors++; $display("FAIL toggle_settle: got %0d want 9", code); end
    step(1);
  endtask
  task automatic test_invalid;
    int n;
    seg = 7'h55;
    wait_valid(12, n);
    checks++; if (code !== 5'd31 || code_err !== 1'b1) begin errors++; $display("FAIL inv_code: got %0d err %b want 31/1", code, code_err); end
`ifdef SEG7_ERR_CNT_EN
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL inv_err_count: got %0d want 1", err_count); end
`endif
    step(1);
  endtask
  task automatic test_overrun;
    int n, ov, bad;
    code_ready = 0;
    seg = 7'h5B;
    wait_valid(12, n);
    checks++; if (code !== 5'd2) begin errors++; $display("FAIL ovr_first: got %0d want 2", code); end
    seg = 7'h40;
    ov = 0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (overrun) ov++;
      if (code_valid !== 1'b1 || code !== 5'd2) bad++;
    end
    checks++; if (ov != 1) begin errors++; $display("FAIL ovr_pulse: got %0d pulse cycles want 1", ov); end
    checks++; if (bad != 0) begin errors++; $display("FAIL ovr_kept: got %0d changed cycles want 0", bad); end
    code_ready = 1;
    step(1);
    checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL ovr_release: got %b want 0", code_valid); end
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (code_valid) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL ovr_no_rereport: got %0d valid cycles want 0", n); end
  endtask
  task automatic test_back_to_back;
    int n;
    code_ready = 0;
    seg = 7'h07;
    wait_valid(12, n);
    checks++; if (code !== 5'd7) begin errors++; $display("FAIL b2b_first: got %0d want 7", code); end
    seg = 7'h7C;
    step(6);
    checks++; if (code_valid !== 1'b1 || code !== 5'd7) begin errors++; $display("FAIL b2b_pending: got valid %b code %0d want 1/7", code_valid, code); end
    code_ready = 1;
    step(1);
    checks++; if (code_valid !== 1'b1 || code !== 5'd11 || overrun !== 1'b0) begin errors++; $display("FAIL b2b_swap: got valid %b code %0d ovr %b want 1/11/0", code_valid, code, overrun); end
    step(1);
    checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL b2b_clear: got %b want 0", code_valid); end
  endtask
  task automatic test_reset_hold;
    int n;
    code_ready = 0;
    seg = 7'h4F;
    wait_valid(12, n);
    checks++; if (code !== 5'd3) begin errors++; $display("FAIL rh_first: got %0d want 3", code); end
    seg = 7'h00;
    rst_n = 0;
    #1;
    checks++; if (code_valid !== 1'b0 || code !== 5'd0) begin errors++; $display("FAIL rh_async: got valid %b code %0d want 0/0", code_valid, code); end
    step(1);
    rst_n = 1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (code_valid) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL rh_blank: got %0d valid cycles want 0", n); end
  endtask
  initial begin
    clk = 0;
    rst_n = 0;
    seg = '0;
    seg1 = '0;
    code_ready = 0;
    test_reset;
    test_stable1;
    test_latency;
    test_hold;
    test_toggle;
    test_invalid;
    test_overrun;
    test_back_to_back;
    test_reset_hold;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
